// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in/serial-out transmitter, LSB first, gapless back-to-back frames
// PISO_PARITY_EN adds one even-parity trailer cycle per frame.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);

  // Ready is decoded from state only so the producer never sees a path from load_valid.
`ifdef PISO_PARITY_EN
  logic par;
  assign load_ready = (state == IDLE) || (state == PARITY);
`else
  assign load_ready = (state == IDLE) || last_bit;
`endif

  assign accept = load_valid & load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame_done <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            shreg <= load_data;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= ^load_data;
`endif
          end
        end
        SHIFT: begin
          sout       <= shreg[0];
          sout_valid <= 1'b1;
          shreg      <= shreg >> 1;
          cnt        <= cnt + 1'b1;
          if (last_bit) begin
`ifdef PISO_PARITY_EN
            state <= PARITY;
`else
            frame_done <= 1'b1;
            // A word accepted on the final bit starts its bit0 on the next edge.
            if (accept) begin
              shreg <= load_data;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          sout       <= par;
          sout_valid <= 1'b1;
          frame_done <= 1'b1;
          if (accept) begin
            state <= SHIFT;
            shreg <= load_data;
            cnt   <= '0;
            par   <= ^load_data;
          end else begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed self-checking bench for piso_tx (WIDTH=4), PISO_PARITY_EN aware
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = 4'h0;
  logic       load_ready;
  logic       sout;
  logic       sout_valid;
  logic       frame_done;
  logic [3:0] rx_q = 4'h0;

  int n_assert = 0;
  int n_fail = 0;

  piso_tx #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Existing 4-bit SIPO receiver: serial bit enters at the MSB and walks down to q[0].
  always @(posedge clk) rx_q <= {sout, rx_q[3:1]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq8;
    logic [3:0] words [3];
    logic [4:0] pbits;

    #1;
    chk("rst_sout", sout, 0);
    chk("rst_valid", sout_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", load_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

`ifndef PISO_PARITY_EN
    // 1: single frame 4'b1011
    load_valid = 1'b1;
    load_data  = 4'b1011;
    tick();
    load_valid = 1'b0;
    chk("t1_valid_n", sout_valid, 0);
    chk("t1_ready_n", load_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t1_sout%0d", k), sout, (k == 1 || k == 0 || k == 3) ? 1 : 0);
      chk($sformatf("t1_valid%0d", k), sout_valid, 1);
      chk($sformatf("t1_done%0d", k), frame_done, (k == 3) ? 1 : 0);
      chk($sformatf("t1_ready%0d", k), load_ready, (k >= 2) ? 1 : 0);
    end
    tick();
    chk("t1_idle_valid", sout_valid, 0);
    chk("t1_idle_sout", sout, 0);
    chk("t1_idle_done", frame_done, 0);

    // 2: back-to-back 4'hA then 4'h5
    seq8 = 8'b0101_1010;  // bit i = expected sout on tick i (LSB first)
    load_valid = 1'b1;
    load_data  = 4'hA;
    tick();
    load_data  = 4'h5;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_sout%0d", i), sout, seq8[i]);
      chk($sformatf("t2_valid%0d", i), sout_valid, 1);
      chk($sformatf("t2_done%0d", i), frame_done, (i == 3 || i == 7) ? 1 : 0);
      if (i == 3) load_valid = 1'b0;
    end
    tick();
    chk("t2_tail_valid", sout_valid, 0);

    // 3: 4'hF offered while a 4'h0 frame is busy
    load_valid = 1'b1;
    load_data  = 4'h0;
    tick();
    load_valid = 1'b0;
    tick();
    chk("t3_sout0", sout, 0);
    load_valid = 1'b1;
    load_data  = 4'hF;
    tick();
    chk("t3_sout1", sout, 0);
    chk("t3_ready1", load_ready, 0);
    tick();
    chk("t3_sout2", sout, 0);
    chk("t3_ready2", load_ready, 1);
    tick();
    chk("t3_sout3", sout, 0);
    chk("t3_done3", frame_done, 1);
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_f_sout%0d", i), sout, 1);
      chk($sformatf("t3_f_done%0d", i), frame_done, (i == 3) ? 1 : 0);
    end
    tick();

    // 4: reset mid-frame of 4'hC, then 4'h3
    load_valid = 1'b1;
    load_data  = 4'hC;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    chk("t4_mid_valid", sout_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_sout", sout, 0);
    chk("t4_async_valid", sout_valid, 0);
    chk("t4_async_done", frame_done, 0);
    chk("t4_async_ready", load_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_quiet_done%0d", i), frame_done, 0);
      chk($sformatf("t4_quiet_valid%0d", i), sout_valid, 0);
    end
    load_valid = 1'b1;
    load_data  = 4'h3;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_sout%0d", i), sout, (i < 2) ? 1 : 0);
      chk($sformatf("t4_done%0d", i), frame_done, (i == 3) ? 1 : 0);
    end
    tick();

    // 5: loopback into SIPO, words 1, 8, 6 back-to-back
    words[0] = 4'h1;
    words[1] = 4'h8;
    words[2] = 4'h6;
    load_valid = 1'b1;
    load_data  = words[0];
    tick();
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i < 12) begin
        chk($sformatf("t5_sout%0d", i), sout, words[i / 4][i % 4]);
        chk($sformatf("t5_done%0d", i), frame_done, (i % 4 == 3) ? 1 : 0);
      end
      if (i > 0 && i % 4 == 0)
        chk($sformatf("t5_rxq%0d", i / 4 - 1), rx_q, words[i / 4 - 1]);
      if (i == 0) load_data = words[1];
      if (i == 4) load_data = words[2];
      if (i == 8) load_valid = 1'b0;
    end
    chk("t5_end_valid", sout_valid, 0);
`else
    // 6: even parity trailer
    pbits = 5'b1_1011;  // 4'b1011 then parity 1
    load_valid = 1'b1;
    load_data  = 4'b1011;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t6a_sout%0d", k), sout, pbits[k]);
      chk($sformatf("t6a_valid%0d", k), sout_valid, 1);
      chk($sformatf("t6a_done%0d", k), frame_done, (k == 4) ? 1 : 0);
      chk($sformatf("t6a_ready%0d", k), load_ready, (k >= 3) ? 1 : 0);
    end
    tick();
    chk("t6a_idle_valid", sout_valid, 0);

    pbits = 5'b0_1001;  // 4'b1001 then parity 0
    load_valid = 1'b1;
    load_data  = 4'b1001;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t6b_sout%0d", k), sout, pbits[k]);
      chk($sformatf("t6b_done%0d", k), frame_done, (k == 4) ? 1 : 0);
    end
    tick();
    chk("t6b_idle_valid", sout_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
